// File: rtl/channel_pkg.sv
// Shared types for the CSP rendezvous channel: protocol select, status codes and FSM states.
package channel_pkg;

    typedef enum logic {
        P2PHASE_BD,
        P4PHASE_BD
    } hs_protocol_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        R_PEND    = 2'd1,
        S_PEND    = 2'd2,
        S12M_PEND = 2'd3
    } chan_status_e;

    typedef enum logic [1:0] {
        StWait,
        StXfer,
        StRtz,
        StDone
    } chan_state_e;

endpackage

// File: rtl/channel_if.sv
// Sender/receiver bundle of one channel link; master drives requests, slave is the channel.
interface channel_if
    import channel_pkg::*;
#(
    parameter int unsigned WIDTH = 33
);
    logic             send_req;
    logic [WIDTH-1:0] send_data;
    logic             send_done;
    logic             recv_req;
    logic [WIDTH-1:0] recv_data;
    logic             recv_done;
    logic             req;
    logic             ack;
    chan_status_e     status;

    modport master (
        output send_req, send_data, recv_req,
        input  send_done, recv_data, recv_done, req, ack, status
    );

    modport slave (
        input  send_req, send_data, recv_req,
        output send_done, recv_data, recv_done, req, ack, status
    );
endinterface

// File: rtl/chan_handshake.sv
// Generates the link req/ack wires for 2-phase or 4-phase bundled data and reports
// which phase the wires are currently in back to the channel FSM.
module chan_handshake
    import channel_pkg::*;
#(
    parameter hs_protocol_e HS_PROTOCOL = P2PHASE_BD
)(
    input  logic        clk,
    input  logic        rst_n,
    input  chan_state_e state,
    input  logic        match,
    output logic        req,
    output logic        ack,
    output logic        ack_phase,
    output logic        rtz_phase
);
    localparam bit TwoPhase = (HS_PROTOCOL == P2PHASE_BD);

    logic req_q;
    logic ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            case (state)
                StWait: begin
                    if (match) begin
                        req_q <= TwoPhase ? ~req_q : 1'b1;
                    end
                end
                StXfer: begin
                    if (TwoPhase) begin
                        ack_q <= req_q;
                    end else begin
                        ack_q <= 1'b1;
                        req_q <= 1'b0;
                    end
                end
                StRtz: begin
                    ack_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // An outstanding request is a level difference in 2-phase, a raised req in 4-phase.
    assign ack_phase = TwoPhase ? (req_q ^ ack_q) : (req_q & ~ack_q);
    assign rtz_phase = ~TwoPhase & ack_q & ~req_q;
    assign req       = req_q;
    assign ack       = ack_q;

endmodule

// File: rtl/channel.sv
// Zero-slack point-to-point rendezvous channel: matches one sender with one receiver,
// registers the packet and pulses both done outputs together.
module channel
    import channel_pkg::*;
#(
    parameter int unsigned  WIDTH       = 33,
    parameter hs_protocol_e HS_PROTOCOL = P2PHASE_BD
)(
    input logic      clk,
    input logic      rst_n,
    channel_if.slave ch
);
    localparam bit TwoPhase = (HS_PROTOCOL == P2PHASE_BD);

    chan_state_e      state_q;
    logic [WIDTH-1:0] data_q;
    logic             done_q;
    logic             match;
    logic             hs_req;
    logic             hs_ack;
    logic             ack_phase;
    logic             rtz_phase;

    assign match = (state_q == StWait) && ch.send_req && ch.recv_req;

    chan_handshake #(
        .HS_PROTOCOL (HS_PROTOCOL)
    ) u_handshake (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state_q),
        .match     (match),
        .req       (hs_req),
        .ack       (hs_ack),
        .ack_phase (ack_phase),
        .rtz_phase (rtz_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StWait;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StWait: begin
                    if (match) begin
                        data_q  <= ch.send_data;
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (ack_phase) begin
                        if (TwoPhase) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRtz;
                        end
                    end
                end
                StRtz: begin
                    if (rtz_phase) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                // Requests seen on the way out of DONE are deliberately dropped.
                StDone:  state_q <= StWait;
                default: state_q <= StWait;
            endcase
        end
    end

    always_comb begin
        ch.status = S12M_PEND;
        if (state_q == StWait) begin
            ch.status = chan_status_e'({ch.send_req, ch.recv_req});
        end
    end

    assign ch.send_done = done_q;
    assign ch.recv_done = done_q;
    assign ch.recv_data = data_q;
    assign ch.req       = hs_req;
    assign ch.ack       = hs_ack;

endmodule

// File: tb/tb_channel.sv
// Directed bench for the 2-phase and 4-phase channel variants.
module tb_channel;
    import channel_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    channel_if #(.WIDTH(33)) if2 ();
    channel_if #(.WIDTH(33)) if4 ();

    channel #(.WIDTH(33), .HS_PROTOCOL(P2PHASE_BD)) u2 (.clk(clk), .rst_n(rst_n), .ch(if2));
    channel #(.WIDTH(33), .HS_PROTOCOL(P4PHASE_BD)) u4 (.clk(clk), .rst_n(rst_n), .ch(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if2.send_req = 1'b0; if2.recv_req = 1'b0; if2.send_data = '0;
        if4.send_req = 1'b0; if4.recv_req = 1'b0; if4.send_data = '0;
        #12;
        total++; if (if2.req !== 1'b0 || if2.ack !== 1'b0) begin bad++;
            $display("FAIL reset2_wires req=%b ack=%b want 0 0", if2.req, if2.ack); end
        total++; if (if2.recv_data !== 33'h0 || if2.send_done !== 1'b0 || if2.recv_done !== 1'b0) begin bad++;
            $display("FAIL reset2_regs data=%h sd=%b rd=%b want 0", if2.recv_data, if2.send_done, if2.recv_done); end
        total++; if (if4.req !== 1'b0 || if4.ack !== 1'b0 || if4.send_done !== 1'b0) begin bad++;
            $display("FAIL reset4 req=%b ack=%b done=%b want 0", if4.req, if4.ack, if4.send_done); end
        total++; if (if2.status !== IDLE) begin bad++;
            $display("FAIL reset_status got=%0d want 0", if2.status); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_two_phase;
        if2.send_req = 1'b1; if2.send_data = 33'h1_2345_6789;
        #1;
        total++; if (if2.status !== S_PEND) begin bad++;
            $display("FAIL tp_status_spend got=%0d want 2", if2.status); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (if2.status !== S_PEND || if2.send_done !== 1'b0) begin bad++;
                $display("FAIL tp_wait_%0d status=%0d done=%b want 2 0", i, if2.status, if2.send_done); end
        end
        if2.recv_req = 1'b1;
        #1;
        total++; if (if2.status !== S12M_PEND || if2.req !== 1'b0) begin bad++;
            $display("FAIL tp_prematch status=%0d req=%b want 3 0", if2.status, if2.req); end
        tick();
        total++; if (if2.req !== 1'b1 || if2.ack !== 1'b0 || if2.send_done !== 1'b0) begin bad++;
            $display("FAIL tp_match req=%b ack=%b done=%b want 1 0 0", if2.req, if2.ack, if2.send_done); end
        total++; if (if2.status !== S12M_PEND || if2.recv_data !== 33'h1_2345_6789) begin bad++;
            $display("FAIL tp_capture status=%0d data=%h want 3 123456789", if2.status, if2.recv_data); end
        tick();
        total++; if (if2.ack !== 1'b1 || if2.send_done !== 1'b1 || if2.recv_done !== 1'b1) begin bad++;
            $display("FAIL tp_done ack=%b sd=%b rd=%b want 1 1 1", if2.ack, if2.send_done, if2.recv_done); end
        if2.send_req = 1'b0; if2.recv_req = 1'b0;
        tick();
        total++; if (if2.send_done !== 1'b0 || if2.status !== IDLE || if2.recv_data !== 33'h1_2345_6789) begin bad++;
            $display("FAIL tp_after done=%b status=%0d data=%h want 0 0 123456789",
                     if2.send_done, if2.status, if2.recv_data); end
    endtask

    task automatic test_recv_first;
        if2.recv_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (if2.status !== R_PEND || if2.recv_done !== 1'b0) begin bad++;
                $display("FAIL rf_wait_%0d status=%0d done=%b want 1 0", i, if2.status, if2.recv_done); end
        end
        if2.send_req = 1'b1; if2.send_data = 33'h0_0ABC_DEF1;
        tick();
        tick();
        total++; if (if2.recv_done !== 1'b1 || if2.recv_data !== 33'h0_0ABC_DEF1) begin bad++;
            $display("FAIL rf_done done=%b data=%h want 1 0abcdef1", if2.recv_done, if2.recv_data); end
        total++; if (if2.req !== 1'b0 || if2.ack !== 1'b0) begin bad++;
            $display("FAIL rf_wires req=%b ack=%b want 0 0", if2.req, if2.ack); end
        if2.send_req = 1'b0; if2.recv_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        if2.send_req = 1'b1; if2.recv_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if2.send_data = 33'(k);
            tick();
            total++; if (if2.send_done !== 1'b0) begin bad++;
                $display("FAIL b2b_match_%0d done=%b want 0", k, if2.send_done); end
            tick();
            total++; if (if2.send_done !== 1'b1 || if2.recv_data !== 33'(k)) begin bad++;
                $display("FAIL b2b_done_%0d done=%b data=%0d want 1 %0d", k, if2.send_done, if2.recv_data, k); end
            if (k == 4) begin
                if2.send_req = 1'b0; if2.recv_req = 1'b0;
            end
            tick();
            total++; if (if2.send_done !== 1'b0 || if2.status !== S12M_PEND && k != 4) begin bad++;
                $display("FAIL b2b_gap_%0d done=%b status=%0d", k, if2.send_done, if2.status); end
        end
        total++; if (if2.req !== 1'b0 || if2.ack !== 1'b0 || if2.status !== IDLE) begin bad++;
            $display("FAIL b2b_end req=%b ack=%b status=%0d want 0 0 0", if2.req, if2.ack, if2.status); end
    endtask

    task automatic test_four_phase;
        if4.send_req = 1'b1; if4.recv_req = 1'b1; if4.send_data = 33'h1_F00D_CAFE;
        tick();
        total++; if (if4.req !== 1'b1 || if4.ack !== 1'b0 || if4.send_done !== 1'b0) begin bad++;
            $display("FAIL fp_match req=%b ack=%b done=%b want 1 0 0", if4.req, if4.ack, if4.send_done); end
        tick();
        total++; if (if4.req !== 1'b0 || if4.ack !== 1'b1 || if4.send_done !== 1'b0) begin bad++;
            $display("FAIL fp_ack req=%b ack=%b done=%b want 0 1 0", if4.req, if4.ack, if4.send_done); end
        tick();
        total++; if (if4.req !== 1'b0 || if4.ack !== 1'b0 || if4.send_done !== 1'b1 || if4.recv_done !== 1'b1) begin bad++;
            $display("FAIL fp_done req=%b ack=%b sd=%b rd=%b want 0 0 1 1",
                     if4.req, if4.ack, if4.send_done, if4.recv_done); end
        total++; if (if4.recv_data !== 33'h1_F00D_CAFE) begin bad++;
            $display("FAIL fp_data got=%h want 1f00dcafe", if4.recv_data); end
        if4.send_req = 1'b0; if4.recv_req = 1'b0;
        tick();
        total++; if (if4.send_done !== 1'b0 || if4.status !== IDLE || if4.req !== 1'b0) begin bad++;
            $display("FAIL fp_after done=%b status=%0d req=%b want 0 0 0", if4.send_done, if4.status, if4.req); end
    endtask

    task automatic test_probe;
        if2.send_req = 1'b1; if2.send_data = 33'h0_5555_5555;
        #1;
        total++; if (if2.status !== S_PEND) begin bad++;
            $display("FAIL pr_status_on got=%0d want 2", if2.status); end
        tick();
        total++; if (if2.status !== S_PEND || if2.req !== 1'b0 || if2.send_done !== 1'b0) begin bad++;
            $display("FAIL pr_hold status=%0d req=%b done=%b want 2 0 0", if2.status, if2.req, if2.send_done); end
        tick();
        if2.send_req = 1'b0;
        #1;
        total++; if (if2.status !== IDLE) begin bad++;
            $display("FAIL pr_status_off got=%0d want 0", if2.status); end
        tick();
        total++; if (if2.req !== 1'b0 || if2.ack !== 1'b0 || if2.send_done !== 1'b0 || if2.recv_data !== 33'h4) begin bad++;
            $display("FAIL pr_nochange req=%b ack=%b done=%b data=%h want 0 0 0 4",
                     if2.req, if2.ack, if2.send_done, if2.recv_data); end
    endtask

    task automatic test_mid_reset;
        if2.send_req = 1'b1; if2.recv_req = 1'b1; if2.send_data = 33'h1_AAAA_0001;
        tick();
        total++; if (if2.req !== 1'b1 || if2.recv_data !== 33'h1_AAAA_0001) begin bad++;
            $display("FAIL mr_xfer req=%b data=%h want 1 1aaaa0001", if2.req, if2.recv_data); end
        rst_n = 1'b0;
        #1;
        total++; if (if2.req !== 1'b0 || if2.ack !== 1'b0 || if2.recv_data !== 33'h0 || if2.send_done !== 1'b0) begin bad++;
            $display("FAIL mr_abort req=%b ack=%b data=%h done=%b want 0 0 0 0",
                     if2.req, if2.ack, if2.recv_data, if2.send_done); end
        if2.send_req = 1'b0; if2.recv_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (if2.send_done !== 1'b0 || if2.status !== IDLE) begin bad++;
            $display("FAIL mr_quiet done=%b status=%0d want 0 0", if2.send_done, if2.status); end
        if2.send_req = 1'b1; if2.recv_req = 1'b1; if2.send_data = 33'h0_1357_9BDF;
        tick();
        tick();
        total++; if (if2.send_done !== 1'b1 || if2.recv_data !== 33'h0_1357_9BDF || if2.ack !== 1'b1) begin bad++;
            $display("FAIL mr_fresh done=%b data=%h ack=%b want 1 013579bdf 1",
                     if2.send_done, if2.recv_data, if2.ack); end
        if2.send_req = 1'b0; if2.recv_req = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_two_phase();
        test_recv_first();
        test_back_to_back();
        test_four_phase();
        test_probe();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
